// File: rtl/sdram_arbiter.sv
// N-port request arbiter in front of the single-port SDRAM controller command interface.
// Grants one client at a time, holds its command until ack, and times out if the controller never answers.
module sdram_arbiter #(
    parameter int NPORT   = 4,
    parameter int AW      = 25,
    parameter int DW      = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 1023,
    localparam int BW     = DW / 8
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic [NPORT-1:0]    req_write,
    input  logic [NPORT-1:0]    req_read,
    input  logic [NPORT*AW-1:0] req_adrs,
    input  logic [NPORT*DW-1:0] req_wdata,
    input  logic [NPORT*BW-1:0] req_de,
    output logic [NPORT-1:0]    port_ack,
    output logic [NPORT-1:0]    port_err,
    output logic [DW-1:0]       port_rdata,
    output logic [2:0]          grant_id,
    output logic                sdram_write,
    output logic                sdram_read,
    output logic [AW-1:0]       sdram_adrs,
    output logic [DW-1:0]       sdram_wdata,
    output logic [BW-1:0]       sdram_de,
    input  logic [DW-1:0]       sdram_rdata,
    input  logic                sdram_ack,
    input  logic                sdram_err,
    input  logic                sdram_refresh_doing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [15:0]       cnt_r, cnt_s;
    logic [2:0]        last_r, last_s;
    logic [2:0]        grant_r, grant_s;
    logic              write_r, write_s;
    logic              read_r, read_s;
    logic [AW-1:0]     adrs_r, adrs_s;
    logic [DW-1:0]     wdata_r, wdata_s;
    logic [BW-1:0]     de_r, de_s;
    logic [NPORT-1:0]  ack_r, ack_s;
    logic [NPORT-1:0]  err_r, err_s;
    logic [DW-1:0]     rdata_r, rdata_s;

    logic [NPORT-1:0]  pend_s;
    logic [2:0]        sel_s;
    logic [3:0]        idx_s;
    logic              sel_wr_s;
    logic [AW-1:0]     sel_adrs_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [BW-1:0]     sel_de_s;
    logic [NPORT-1:0]  onehot_s;

    // Grant selection: rotating search from last+1, or lowest pending index.
    always_comb begin
        pend_s = req_write | req_read;
        sel_s  = 3'd0;
        idx_s  = 4'd0;
        if (RR_MODE != 0) begin
            // Walk the distance downward so the nearest pending port is written last.
            for (int k = NPORT; k >= 1; k--) begin
                idx_s = {1'b0, last_r} + 4'(k);
                if (idx_s >= 4'(NPORT)) begin
                    idx_s = idx_s - 4'(NPORT);
                end else begin
                    idx_s = idx_s;
                end
                for (int i = 0; i < NPORT; i++) begin
                    if (pend_s[i] && (idx_s == 4'(i))) begin
                        sel_s = 3'(i);
                    end else begin
                        sel_s = sel_s;
                    end
                end
            end
        end else begin
            for (int i = NPORT - 1; i >= 0; i--) begin
                if (pend_s[i]) begin
                    sel_s = 3'(i);
                end else begin
                    sel_s = sel_s;
                end
            end
        end
    end

    // Request field mux for the candidate port and one-hot of the current grant.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_adrs_s  = '0;
        sel_wdata_s = '0;
        sel_de_s    = '0;
        onehot_s    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel_s == 3'(i)) begin
                sel_wr_s    = req_write[i];
                sel_adrs_s  = req_adrs[i*AW +: AW];
                sel_wdata_s = req_wdata[i*DW +: DW];
                sel_de_s    = req_de[i*BW +: BW];
            end else begin
                sel_wr_s    = sel_wr_s;
            end
            onehot_s[i] = (grant_r == 3'(i));
        end
    end

    // Next-state and next-output logic of the IDLE/BUSY/DONE controller.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        grant_s = grant_r;
        write_s = write_r;
        read_s  = read_r;
        adrs_s  = adrs_r;
        wdata_s = wdata_r;
        de_s    = de_r;
        ack_s   = '0;
        err_s   = '0;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                if ((|pend_s) && !sdram_refresh_doing) begin
                    grant_s = sel_s;
                    last_s  = sel_s;
                    // A write wins when both strobes are up; the read is dropped.
                    write_s = sel_wr_s;
                    read_s  = !sel_wr_s;
                    adrs_s  = sel_adrs_s;
                    wdata_s = sel_wdata_s;
                    de_s    = sel_de_s;
                    cnt_s   = 16'd0;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                cnt_s = cnt_r + 16'd1;
                if (sdram_ack) begin
                    write_s = 1'b0;
                    read_s  = 1'b0;
                    if (read_r) begin
                        rdata_s = sdram_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    ack_s   = onehot_s;
                    err_s   = sdram_err ? onehot_s : '0;
                    state_s = DONE;
                end else if (cnt_r == 16'(TIMEOUT - 1)) begin
                    write_s = 1'b0;
                    read_s  = 1'b0;
                    rdata_s = '0;
                    ack_s   = onehot_s;
                    err_s   = onehot_s;
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            last_r  <= 3'(NPORT - 1);
            grant_r <= 3'd0;
            write_r <= 1'b0;
            read_r  <= 1'b0;
            adrs_r  <= '0;
            wdata_r <= '0;
            de_r    <= '0;
            ack_r   <= '0;
            err_r   <= '0;
            rdata_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            write_r <= write_s;
            read_r  <= read_s;
            adrs_r  <= adrs_s;
            wdata_r <= wdata_s;
            de_r    <= de_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            rdata_r <= rdata_s;
        end
    end

    assign sdram_write = write_r;
    assign sdram_read  = read_r;
    assign sdram_adrs  = adrs_r;
    assign sdram_wdata = wdata_r;
    assign sdram_de    = de_r;
    assign port_ack    = ack_r;
    assign port_err    = err_r;
    assign port_rdata  = rdata_r;
    assign grant_id    = grant_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table of single transactions plus hand-written
// round-robin, fixed-priority, timeout and reset sequences, completions checked via a scoreboard.
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              p_reset;
    logic [NP-1:0]     req_write, req_read;
    logic [NP*AW-1:0]  req_adrs;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP*BW-1:0]  req_de;
    logic [DW-1:0]     sdram_rdata;
    logic              sdram_ack, sdram_err, refresh;

    logic [NP-1:0]     port_ack, port_err;
    logic [DW-1:0]     port_rdata;
    logic [2:0]        grant_id;
    logic              sdram_write, sdram_read;
    logic [AW-1:0]     sdram_adrs;
    logic [DW-1:0]     sdram_wdata;
    logic [BW-1:0]     sdram_de;

    logic [NP-1:0]     f_port_ack, f_port_err;
    logic [DW-1:0]     f_port_rdata;
    logic [2:0]        f_grant_id;
    logic              f_sdram_write, f_sdram_read;
    logic [AW-1:0]     f_sdram_adrs;
    logic [DW-1:0]     f_sdram_wdata;
    logic [BW-1:0]     f_sdram_de;

    always #5 clk = ~clk;

    sdram_arbiter #(.NPORT(NP), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(16)) dut (
        .m_clock(clk), .p_reset(p_reset),
        .req_write(req_write), .req_read(req_read), .req_adrs(req_adrs),
        .req_wdata(req_wdata), .req_de(req_de),
        .port_ack(port_ack), .port_err(port_err), .port_rdata(port_rdata), .grant_id(grant_id),
        .sdram_write(sdram_write), .sdram_read(sdram_read), .sdram_adrs(sdram_adrs),
        .sdram_wdata(sdram_wdata), .sdram_de(sdram_de),
        .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack), .sdram_err(sdram_err),
        .sdram_refresh_doing(refresh)
    );

    sdram_arbiter #(.NPORT(NP), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(16)) dut_fp (
        .m_clock(clk), .p_reset(p_reset),
        .req_write(req_write), .req_read(req_read), .req_adrs(req_adrs),
        .req_wdata(req_wdata), .req_de(req_de),
        .port_ack(f_port_ack), .port_err(f_port_err), .port_rdata(f_port_rdata), .grant_id(f_grant_id),
        .sdram_write(f_sdram_write), .sdram_read(f_sdram_read), .sdram_adrs(f_sdram_adrs),
        .sdram_wdata(f_sdram_wdata), .sdram_de(f_sdram_de),
        .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack), .sdram_err(sdram_err),
        .sdram_refresh_doing(refresh)
    );

    typedef struct {
        int          port;
        logic        wr;
        logic        rd;
        logic [24:0] adrs;
        logic [31:0] wdata;
        logic [3:0]  de;
        int          delay;
        int          refresh_cycles;
        logic [31:0] rdata_in;
        logic        err_in;
        logic        exp_write;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[4];
    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_strobe(input bit fp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fp ? (f_sdram_write | f_sdram_read) : (sdram_write | sdram_read)) begin
                ok = 1'b1;
                return;
            end
        end
        chk("strobe_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic push_exp(input int port, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.ack   = 4'(1 << port);
        e.err   = err ? 4'(1 << port) : 4'd0;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb_q.pop_front();
            chk({name, "_ack"},   64'(port_ack),   64'(e.ack));
            chk({name, "_err"},   64'(port_err),   64'(e.err));
            chk({name, "_rdata"}, 64'(port_rdata), 64'(e.rdata));
        end
    endtask

    task automatic clear_reqs();
        req_write = '0;
        req_read  = '0;
        req_adrs  = '0;
        req_wdata = '0;
        req_de    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        p_reset = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);
        p_reset = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit ok;
        @(negedge clk);
        if (v.refresh_cycles > 0) refresh = 1'b1;
        req_write[v.port]            = v.wr;
        req_read[v.port]             = v.rd;
        req_adrs[v.port*AW +: AW]    = v.adrs;
        req_wdata[v.port*DW +: DW]   = v.wdata;
        req_de[v.port*BW +: BW]      = v.de;
        push_exp(v.port, v.exp_err, v.exp_rdata);
        for (int r = 0; r < v.refresh_cycles; r++) begin
            @(negedge clk);
            chk("refresh_no_strobe", 64'({sdram_write, sdram_read}), 64'(0));
        end
        refresh = 1'b0;
        wait_strobe(1'b0, ok);
        if (ok) begin
            chk("strobe_write", 64'(sdram_write), 64'(v.exp_write));
            chk("strobe_read",  64'(sdram_read),  64'(!v.exp_write));
            chk("cmd_adrs",     64'(sdram_adrs),  64'(v.adrs));
            chk("cmd_wdata",    64'(sdram_wdata), 64'(v.wdata));
            chk("cmd_de",       64'(sdram_de),    64'(v.de));
            chk("grant_id",     64'(grant_id),    64'(v.port));
            req_adrs[v.port*AW +: AW] = ~v.adrs;
            repeat (v.delay) @(negedge clk);
            chk("busy_adrs_held", 64'(sdram_adrs), 64'(v.adrs));
            sdram_ack   = 1'b1;
            sdram_rdata = v.rdata_in;
            sdram_err   = v.err_in;
            @(negedge clk);
            sdram_ack   = 1'b0;
            sdram_err   = 1'b0;
            sdram_rdata = 32'hBADC0FFE;
            pop_check("txn_done");
            chk("strobe_dropped", 64'({sdram_write, sdram_read}), 64'(0));
            req_write[v.port] = 1'b0;
            req_read[v.port]  = 1'b0;
            @(negedge clk);
            chk("ack_pulse_width", 64'(port_ack), 64'(0));
        end
        clear_reqs();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        int e_id;
        p_reset     = 1'b1;
        refresh     = 1'b0;
        sdram_ack   = 1'b0;
        sdram_err   = 1'b0;
        sdram_rdata = '0;
        clear_reqs();

        vecs[0] = '{2, 1'b0, 1'b1, 25'h0001234, 32'h0,        4'h0, 5, 0,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{0, 1'b1, 1'b0, 25'h1FFFFFF, 32'hA5A5A5A5, 4'hF, 1, 0,  32'hFFFFFFFF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{3, 1'b0, 1'b1, 25'h0ABCDE0, 32'h0,        4'h0, 3, 0,  32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1};
        vecs[3] = '{0, 1'b1, 1'b1, 25'h0000040, 32'h11223344, 4'h3, 2, 10, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_strobes", 64'({sdram_write, sdram_read}), 64'(0));
        chk("rst_ack",     64'({port_ack, port_err}),      64'(0));
        chk("rst_grant",   64'(grant_id),                  64'(0));
        p_reset = 1'b0;

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Timeout on a port-1 read: rdata was non-zero before and must be cleared.
        @(negedge clk);
        req_read[1]     = 1'b1;
        req_adrs[AW +: AW] = 25'h0000555;
        push_exp(1, 1'b1, 32'h0);
        wait_strobe(1'b0, ok);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sdram_read) n++;
            else break;
        end
        chk("timeout_strobe_len", 64'(n), 64'(16));
        pop_check("timeout_done");
        clear_reqs();
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("stray_ack_no_pulse", 64'({port_ack, port_err}), 64'(0));
        chk("stray_ack_no_strobe", 64'({sdram_write, sdram_read}), 64'(0));

        // Reset during BUSY of a port-1 read, then a simultaneous 0/2 request.
        @(negedge clk);
        req_read[1]        = 1'b1;
        req_adrs[AW +: AW] = 25'h0000777;
        wait_strobe(1'b0, ok);
        chk("pre_reset_grant", 64'(grant_id), 64'(1));
        @(negedge clk);
        p_reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        chk("mid_rst_strobes", 64'({sdram_write, sdram_read}), 64'(0));
        chk("mid_rst_cmd",     64'({sdram_adrs, sdram_de}),    64'(0));
        chk("mid_rst_wdata",   64'(sdram_wdata),               64'(0));
        chk("mid_rst_port",    64'({port_ack, port_err}),      64'(0));
        chk("mid_rst_rdata",   64'(port_rdata),                64'(0));
        chk("mid_rst_grant",   64'(grant_id),                  64'(0));
        p_reset     = 1'b0;
        req_read[0] = 1'b1;
        req_read[2] = 1'b1;
        wait_strobe(1'b0, ok);
        chk("post_rst_grant", 64'(grant_id), 64'(0));

        // Round-robin fairness with all four ports requesting continuously.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            req_read[p]          = 1'b1;
            req_adrs[p*AW +: AW] = 25'(32'h100 + p);
        end
        for (int k = 0; k < 5; k++) begin
            e_id = k % NP;
            push_exp(e_id, 1'b0, 32'hC0DE0000 + 32'(k));
            wait_strobe(1'b0, ok);
            chk("rr_grant", 64'(grant_id),   64'(e_id));
            chk("rr_adrs",  64'(sdram_adrs), 64'(32'h100 + e_id));
            @(negedge clk);
            sdram_ack   = 1'b1;
            sdram_rdata = 32'hC0DE0000 + 32'(k);
            @(negedge clk);
            sdram_ack   = 1'b0;
            pop_check("rr_done");
            req_read[e_id] = 1'b0;
            @(negedge clk);
            chk("rr_ack_pulse", 64'(port_ack), 64'(0));
            req_read[e_id] = 1'b1;
        end

        // Fixed priority: ports 1 and 3 together, port 1 first, port 3 right after.
        do_reset();
        req_read[1] = 1'b1;
        req_read[3] = 1'b1;
        wait_strobe(1'b1, ok);
        chk("fp_first_grant", 64'(f_grant_id), 64'(1));
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("fp_first_ack", 64'(f_port_ack), 64'(4'b0010));
        req_read[1] = 1'b0;
        @(negedge clk);
        chk("fp_idle_gap", 64'(f_sdram_read), 64'(0));
        @(negedge clk);
        chk("fp_second_strobe", 64'(f_sdram_read), 64'(1));
        chk("fp_second_grant",  64'(f_grant_id),   64'(3));
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("fp_second_ack", 64'(f_port_ack), 64'(4'b1000));
        clear_reqs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
